// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - Shared types and constants for the UDP payload packer
package udp_pkg;

  localparam int ETH_MIN_PAYLOAD = 18;
  localparam int UDP_MAX_PAYLOAD = 1472;

  typedef logic [15:0] udp_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ARMED,
    ST_DATA,
    ST_DONE
  } udp_pack_state_t;

  function automatic udp_len_t pad_len(input udp_len_t raw, input udp_len_t min_len);
    return (raw < min_len) ? min_len : raw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Show-ahead synchronous FIFO with full/empty/count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_rd;
  logic             do_wr;

  assign count_o   = wptr_q - rptr_q;
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd     = rd_en_i & ~empty_o;
  // A pop frees the slot this cycle, so a write into a full FIFO may proceed alongside it.
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/udp_tx_packer.sv
// rtl/udp_tx_packer.sv - Buffers datagrams and serves them to the UDP frame sender
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int DATA_DEPTH = 2048,
  parameter int LEN_DEPTH  = 8,
  parameter int MAX_LEN    = UDP_MAX_PAYLOAD,
  parameter int MIN_LEN    = ETH_MIN_PAYLOAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_in_ready,
  output logic        o_enable,
  input  logic        i_ready,
  output logic [15:0] o_data_len,
  input  logic        i_rd,
  output logic [7:0]  o_data,
  output logic [3:0]  o_pkt_cnt
);

  localparam int LCW = $clog2(LEN_DEPTH) + 1;
  localparam int DCW = $clog2(DATA_DEPTH) + 1;

  logic            data_full;
  logic            data_empty;
  logic [7:0]      data_head;
  logic [DCW-1:0]  unused_data_count;
  logic            len_full;
  logic            len_empty;
  udp_len_t        len_head;
  logic [LCW-1:0]  len_count;

  udp_len_t        in_cnt_q;
  udp_len_t        in_cnt_inc;
  logic            accept;
  logic            commit;
  logic            len_pop;
  logic            rd_ok;
  logic            idx_in_range;
  logic            byte_pop;

  udp_pack_state_t state_q;
  udp_len_t        raw_len_q;
  udp_len_t        idx_q;
  udp_len_t        data_len_q;
  logic            enable_q;

  assign o_in_ready = rst_n & ~data_full & ~len_full;
  assign accept     = i_valid & o_in_ready;
  assign in_cnt_inc = in_cnt_q + 16'd1;
  assign commit     = accept & (i_last | (in_cnt_inc == udp_len_t'(MAX_LEN)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q <= '0;
    end else if (commit) begin
      in_cnt_q <= '0;
    end else if (accept) begin
      in_cnt_q <= in_cnt_inc;
    end
  end

  assign len_pop      = (state_q == ST_IDLE) & ~len_empty & i_ready;
  assign rd_ok        = i_rd & ((state_q == ST_ARMED) | (state_q == ST_DATA));
  // Beyond the committed bytes the sender is fed zero padding without touching the FIFO.
  assign idx_in_range = (idx_q < raw_len_q) & ~data_empty;
  assign byte_pop     = rd_ok & idx_in_range;

  assign o_data     = idx_in_range ? data_head : 8'h00;
  assign o_enable   = enable_q;
  assign o_data_len = data_len_q;
  assign o_pkt_cnt  = (32'(len_count) > 32'd15) ? 4'hf : 4'(len_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      raw_len_q  <= '0;
      idx_q      <= '0;
      data_len_q <= '0;
      enable_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (len_pop) begin
            raw_len_q  <= len_head;
            data_len_q <= pad_len(len_head, udp_len_t'(MIN_LEN));
            idx_q      <= '0;
            enable_q   <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!i_ready) begin
            enable_q <= 1'b0;
            state_q  <= ST_ARMED;
          end
        end
        ST_ARMED, ST_DATA: begin
          if (i_rd) begin
            idx_q   <= idx_q + 16'd1;
            state_q <= ((idx_q + 16'd1) == data_len_q) ? ST_DONE : ST_DATA;
          end
        end
        ST_DONE: begin
          if (i_ready) state_q <= ST_IDLE;
        end
        default: begin
          enable_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_data_i (i_data),
    .rd_en_i   (byte_pop),
    .rd_data_o (data_head),
    .full_o    (data_full),
    .empty_o   (data_empty),
    .count_o   (unused_data_count)
  );

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (LEN_DEPTH)
  ) u_len_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (commit),
    .wr_data_i (in_cnt_inc),
    .rd_en_i   (len_pop),
    .rd_data_o (len_head),
    .full_o    (len_full),
    .empty_o   (len_empty),
    .count_o   (len_count)
  );

endmodule

// File: doc/udp_tx_packer.md
Name: udp_tx_packer

Overview:
- Payload staging stage directly upstream of the UDP/Ethernet frame sender.
- Accepts a byte stream with valid/last framing and buffers complete datagrams.
- Drives the sender's enable/ready handshake and presents the datagram length.
- Serves payload bytes show-ahead on the sender's read strobe, zero-padding short datagrams to the Ethernet minimum.

Parameters:
- DATA_DEPTH, 2048, payload byte buffer depth; power of two; must be >= MAX_LEN.
- LEN_DEPTH, 8, number of committed datagrams that can be queued; power of two.
- MAX_LEN, 1472, maximum UDP payload bytes; longer input is split.
- MIN_LEN, 18, minimum advertised payload length (64-byte Ethernet frame); shorter datagrams are zero-padded.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  8  input payload byte
- i_valid  in  1  i_data valid
- i_last  in  1  i_data is the final byte of a datagram
- o_in_ready  out  1  input accepted this cycle when i_valid & o_in_ready
- o_enable  out  1  request to sender (sender's i_enable)
- i_ready  in  1  sender idle (sender's o_ready)
- o_data_len  out  16  payload length for the current datagram (sender's i_data_len)
- i_rd  in  1  sender consuming a payload byte this cycle
- o_data  out  8  current payload byte, show-ahead (sender's i_in_data)
- o_pkt_cnt  out  4  committed datagrams waiting, saturating view of the length queue

Behaviour:
- Reset values: o_enable=0, o_data_len=0, o_data=0, o_in_ready=0 during reset (1 after reset if space is available), o_pkt_cnt=0. Both queues are emptied and the input byte counter is cleared.
- Mid-operation reset aborts everything. A partially received or partially sent datagram is discarded.
- Input side:
  - o_in_ready = !data_full & !len_full.
  - Each accepted byte is written to the data FIFO and increments in_cnt (16 bit).
  - When i_last, or in_cnt+1 == MAX_LEN, the value in_cnt+1 is pushed to the length FIFO and in_cnt is cleared, all in the same cycle as the byte write.
  - Accepted bytes that arrive after the split are the start of the next datagram.
- Output FSM states: IDLE, REQ, ARMED, DATA, DONE.
  - IDLE: if the length FIFO is non-empty and i_ready=1, pop the length, latch raw_len, set o_data_len=max(raw_len,MIN_LEN), clear idx, and go to REQ.
  - REQ: o_enable=1. When i_ready=0, go to ARMED.
  - ARMED: o_enable=0. On the first i_rd, go to DATA and handle that cycle's byte as in DATA.
  - DATA: on each i_rd:
    - if idx < raw_len, o_data = FIFO head and pop;
    - otherwise o_data = 8'h00 with no pop.
    - idx increments in both cases.
  - DATA exit: when idx reaches o_data_len (after the last read), go to DONE. Any i_rd outside ARMED/DATA is ignored: no pop.
  - DONE: wait for i_ready=1 (sender finished, enable already low), then go to IDLE.
- o_data_len is held stable from REQ until DONE exits. o_data shows the head byte combinationally whenever idx < raw_len, else 0.
- Latency: the first datagram byte is readable by the sender 0 cycles after the commit cycle plus the FSM handshake, which is at least 2 cycles to o_enable.
- Simultaneous push and pop on the data FIFO is legal when full or empty. A pop and push in the same cycle leave the occupancy unchanged.
- Pointers are log2(depth)+1 bits and wrap naturally.
- raw_len is never 0, because the input always commits at least 1 byte.

Decomposition:
- Package udp_pkg holds:
  - the FSM enum (udp_pack_state_t);
  - constants ETH_MIN_PAYLOAD=18 and UDP_MAX_PAYLOAD=1472;
  - the 16-bit length typedef.
- Sub-module sync_fifo (WIDTH, DEPTH; show-ahead read, full/empty/count) is instantiated twice: bytes and lengths.

Test Plan:
- Send 32 bytes 0x00..0x1F with last on 0x1F, using a sender model. Expect:
  - o_enable rises while i_ready=1 and drops after i_ready=0;
  - o_data_len=32;
  - 32 reads return 0x00..0x1F;
  - the FSM returns to IDLE when i_ready goes high.
- Send a 5-byte datagram AA BB CC DD EE. Expect:
  - o_data_len=18;
  - reads return AA..EE followed by 13×00;
  - the data FIFO is empty afterwards.
- Send 1500 bytes without last. Expect:
  - the length FIFO holds 1472, with the remaining 28 bytes pending;
  - after a final byte with last, the second entry is 29.
- Hold the sender busy (i_ready=0) and push 8 one-byte datagrams. Expect:
  - o_pkt_cnt=8 and o_in_ready=0;
  - a 9th byte is stalled.
  - Releasing the sender drains all 8 in order, each with length 18.
- Assert i_valid back-to-back while the sender reads concurrently. Expect no byte loss or duplication across the FIFO wrap at DATA_DEPTH.
- Assert rst_n low during DATA at idx=10. Expect:
  - o_enable=0, o_pkt_cnt=0, FIFOs empty;
  - a new datagram after reset is sent correctly.
